stack_control_fsm: RTL
======================

Name: stack_control_fsm

Overview:
- Multi-cycle control unit for the stack processor datapath. Decodes the 16-bit IR and sequences every datapath control strobe (IR/PC/stack/memory) through fetch, decode, execute and writeback states.
- Sits beside the datapath: consumes its IR bus and overflow flag, drives all its control inputs, and reports halt/fault to the top level.

Parameters:
- MEM_LAT, 1, memory read wait cycles (1..3) counted in MEM_RD before writeback.
- FAULT_ON_OVF, 1, when 1 an ALU overflow on ADD/SUB/ADDI aborts to FAULT without writeback; when 0 overflow is ignored.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  level; leaves IDLE when 1.
- ir  in  16  instruction register contents; opcode = ir[15:12].
- overflow  in  1  datapath ALU overflow.
- popAmt  out  1  0 = pop one, 1 = pop two.
- ESOp  out  2  00 none, 01 push, 10 pop, 11 pop(popAmt) then push.
- ESAct  out  1  stack operation enable.
- IRwrite  out  1  latch memory output into IR.
- ALUSrcB  out  1  0 = B (second of stack), 1 = sign-extended immediate.
- ALUop  out  2  00 add, 01 sub, 10 and, 11 or.
- PCSrc  out  2  00 PC+1, 01 IR jump target, 10 A (top of stack), 11 PC+SE branch.
- PushSrc  out  3  000 ALUOut, 001 Memout, 010 SE immediate, 011 shifter.
- ShiftSrc  out  1  shift direction = ir[11] (0 left, 1 right).
- ShamtSrc  out  1  = ir[10] (0 imm ir[3:0], 1 from B).
- regWrite  out  1  push-value register write.
- IorD  out  1  memory address: 0 PC, 1 ALUOut.
- wea  out  1  memory write enable.
- PCwrite  out  1  unconditional PC write.
- BEQCond  out  1  PC written if zero.
- BNECond  out  1  PC written if not zero.
- halted  out  1  in HALT or FAULT.
- fault  out  1  in FAULT.
- state  out  4  current state code, debug.

Behaviour:
- Outputs are Moore: a combinational function of the state register plus ir[15:10]. Every strobe is 0 in any state not listed below.
- States: IDLE 0, FETCH 1, DECODE 2, EXEC 3, ADDR 4, MEM_RD 5, MEM_WR 6, WB 7, HALT 8, FAULT 9.
- Reset (reset=0, any time, mid-instruction included): state = IDLE, MEM_LAT counter = 0, all outputs 0. Recovery begins on the first clk edge after reset returns to 1.
- IDLE: wait while run=0; run=1 → FETCH.
- FETCH: IorD=0, IRwrite=1, PCwrite=1, PCSrc=00 → DECODE.
- DECODE: no strobes. Dispatch on opcode:
  - 0 HALT → HALT.
  - 1 PUSHI, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 ADDI, 7 SHIFT → EXEC.
  - 8 LOAD, 9 STORE → ADDR.
  - A BEQ, B BNE, C JUMP, D JR, E POP → EXEC.
  - F → FAULT.
- EXEC, per opcode:
  - PUSHI: PushSrc=010, regWrite=1, ESAct=1, ESOp=01 → FETCH.
  - ADD/SUB/AND/OR: ALUSrcB=0, ALUop = opcode−2 → WB.
  - ADDI: ALUSrcB=1, ALUop=00 → WB.
  - SHIFT: ShiftSrc, ShamtSrc driven from ir → WB.
  - BEQ/BNE: ALUSrcB=0, ALUop=01, PCSrc=11, BEQCond or BNECond=1, PCwrite=0, ESAct=1, ESOp=10, popAmt=1 → FETCH.
  - JUMP: PCSrc=01, PCwrite=1 → FETCH.
  - JR: PCSrc=10, PCwrite=1, ESAct=1, ESOp=10, popAmt=0 → FETCH.
  - POP: ESAct=1, ESOp=10, popAmt=0 → FETCH.
- Overflow: when FAULT_ON_OVF=1 and overflow=1 in EXEC for ADD/SUB/ADDI → FAULT; WB is not entered and the stack is unchanged.
- WB: regWrite=1, ESAct=1, ESOp=11. ALU ops keep ALUSrcB/ALUop held.
  - ALU ops: PushSrc=000; popAmt=1 for two-operand ops, 0 for ADDI.
  - SHIFT: PushSrc=011; popAmt = ShamtSrc.
  - LOAD: PushSrc=001, popAmt=0.
  - → FETCH.
- ADDR: ALUSrcB=1, ALUop=00 (A+SE). LOAD → MEM_RD with counter cleared; STORE → MEM_WR.
- MEM_RD: IorD=1, ALUSrcB/ALUop held. Counter increments each cycle; → WB when counter = MEM_LAT−1.
- MEM_WR: IorD=1, wea=1 (single cycle), ESAct=1, ESOp=10, popAmt=1 → FETCH.
- HALT and FAULT are absorbing until reset. halted=1 in both; fault=1 in FAULT only.
- Instruction cycle counts: PUSHI/POP/JUMP/JR/BEQ/BNE 3; ALU/SHIFT 4; STORE 4; LOAD 4+MEM_LAT.

Test Plan:
- Reset and run: hold reset=0 for 3 cycles then release with run=0 → state=0, all outputs 0; assert run=1 → next cycle state=1 with IRwrite=1, PCwrite=1, PCSrc=00.
- ir=0x1005 (PUSHI 5) → states 1,2,3,1; in EXEC PushSrc=010, ESOp=01, ESAct=1, regWrite=1.
- ir=0x3000 (SUB) with overflow=0 → WB shows ALUop=01, ESOp=11, popAmt=1; repeat with overflow=1 in EXEC → state=9, fault=1, halted=1, WB never entered.
- ir=0x8004 (LOAD) with MEM_LAT=2 → states 2,4,5,5,7; IorD=1 in both MEM_RD cycles; WB PushSrc=001, popAmt=0.
- ir=0xA010 (BEQ) → EXEC: BEQCond=1, PCwrite=0, PCSrc=11, ESOp=10, popAmt=1; ir=0xB010 → BNECond=1 instead.
- ir=0x9002 (STORE) → MEM_WR: wea=1 for exactly 1 cycle, IorD=1, popAmt=1; then ir=0xF000 → FAULT; ir=0x0000 → HALT, fault=0. Assert reset=0 mid-LOAD (in MEM_RD) → state=0 immediately, asynchronously, without waiting for clk.

Source files
------------

// File: rtl/stack_control_fsm.sv
// Multi-cycle control unit for the stack processor: decodes the IR and sequences
// fetch/decode/execute/memory/writeback strobes for the datapath.
module stack_control_fsm #(
    parameter int MEM_LAT      = 1,
    parameter bit FAULT_ON_OVF = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [15:0] ir,
    input  logic        overflow,
    output logic        popAmt,
    output logic [1:0]  ESOp,
    output logic        ESAct,
    output logic        IRwrite,
    output logic        ALUSrcB,
    output logic [1:0]  ALUop,
    output logic [1:0]  PCSrc,
    output logic [2:0]  PushSrc,
    output logic        ShiftSrc,
    output logic        ShamtSrc,
    output logic        regWrite,
    output logic        IorD,
    output logic        wea,
    output logic        PCwrite,
    output logic        BEQCond,
    output logic        BNECond,
    output logic        halted,
    output logic        fault,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM_RD = 4'd5,
        S_MEM_WR = 4'd6,
        S_WB     = 4'd7,
        S_HALT   = 4'd8,
        S_FAULT  = 4'd9
    } state_t;

    localparam logic [3:0] OP_HALT  = 4'h0;
    localparam logic [3:0] OP_PUSHI = 4'h1;
    localparam logic [3:0] OP_ADD   = 4'h2;
    localparam logic [3:0] OP_SUB   = 4'h3;
    localparam logic [3:0] OP_AND   = 4'h4;
    localparam logic [3:0] OP_OR    = 4'h5;
    localparam logic [3:0] OP_ADDI  = 4'h6;
    localparam logic [3:0] OP_SHIFT = 4'h7;
    localparam logic [3:0] OP_LOAD  = 4'h8;
    localparam logic [3:0] OP_STORE = 4'h9;
    localparam logic [3:0] OP_BEQ   = 4'hA;
    localparam logic [3:0] OP_BNE   = 4'hB;
    localparam logic [3:0] OP_JUMP  = 4'hC;
    localparam logic [3:0] OP_JR    = 4'hD;
    localparam logic [3:0] OP_POP   = 4'hE;

    localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [3:0] opcode;
    logic       is_alu2;
    logic       ir_unused;

    assign opcode    = ir[15:12];
    assign is_alu2   = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                       (opcode == OP_AND) || (opcode == OP_OR);
    assign ir_unused = ^ir[9:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:   if (run) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_HALT:           state_d = S_HALT;
                    OP_LOAD, OP_STORE: state_d = S_ADDR;
                    4'hF:              state_d = S_FAULT;
                    default:           state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_ADDI:
                        state_d = (FAULT_ON_OVF && overflow) ? S_FAULT : S_WB;
                    OP_AND, OP_OR, OP_SHIFT:
                        state_d = S_WB;
                    default:
                        state_d = S_FETCH;
                endcase
            end
            S_ADDR: begin
                cnt_d   = '0;
                state_d = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            // Counter runs from 0 on MEM_RD entry; last wait cycle is MEM_LAT-1.
            S_MEM_RD: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == LAT_LAST) state_d = S_WB;
            end
            S_MEM_WR: state_d = S_FETCH;
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        popAmt   = 1'b0;
        ESOp     = 2'b00;
        ESAct    = 1'b0;
        IRwrite  = 1'b0;
        ALUSrcB  = 1'b0;
        ALUop    = 2'b00;
        PCSrc    = 2'b00;
        PushSrc  = 3'b000;
        ShiftSrc = 1'b0;
        ShamtSrc = 1'b0;
        regWrite = 1'b0;
        IorD     = 1'b0;
        wea      = 1'b0;
        PCwrite  = 1'b0;
        BEQCond  = 1'b0;
        BNECond  = 1'b0;
        halted   = 1'b0;
        fault    = 1'b0;
        case (state_q)
            S_FETCH: begin
                IRwrite = 1'b1;
                PCwrite = 1'b1;
            end
            S_EXEC: begin
                if (is_alu2) ALUop = 2'(opcode - 4'd2);
                case (opcode)
                    OP_PUSHI: begin
                        PushSrc  = 3'b010;
                        regWrite = 1'b1;
                        ESAct    = 1'b1;
                        ESOp     = 2'b01;
                    end
                    OP_ADDI:  ALUSrcB = 1'b1;
                    OP_SHIFT: begin
                        ShiftSrc = ir[11];
                        ShamtSrc = ir[10];
                    end
                    OP_BEQ, OP_BNE: begin
                        ALUop   = 2'b01;
                        PCSrc   = 2'b11;
                        BEQCond = (opcode == OP_BEQ);
                        BNECond = (opcode == OP_BNE);
                        ESAct   = 1'b1;
                        ESOp    = 2'b10;
                        popAmt  = 1'b1;
                    end
                    OP_JUMP: begin
                        PCSrc   = 2'b01;
                        PCwrite = 1'b1;
                    end
                    OP_JR: begin
                        PCSrc   = 2'b10;
                        PCwrite = 1'b1;
                        ESAct   = 1'b1;
                        ESOp    = 2'b10;
                    end
                    OP_POP: begin
                        ESAct = 1'b1;
                        ESOp  = 2'b10;
                    end
                    default: ;
                endcase
            end
            S_ADDR: ALUSrcB = 1'b1;
            S_MEM_RD: begin
                IorD    = 1'b1;
                ALUSrcB = 1'b1;
            end
            S_MEM_WR: begin
                IorD   = 1'b1;
                wea    = 1'b1;
                ESAct  = 1'b1;
                ESOp   = 2'b10;
                popAmt = 1'b1;
            end
            // ALU/shifter inputs stay selected so the pushed value is stable.
            S_WB: begin
                regWrite = 1'b1;
                ESAct    = 1'b1;
                ESOp     = 2'b11;
                if (is_alu2) begin
                    ALUop  = 2'(opcode - 4'd2);
                    popAmt = 1'b1;
                end
                case (opcode)
                    OP_ADDI:  ALUSrcB = 1'b1;
                    OP_SHIFT: begin
                        PushSrc  = 3'b011;
                        ShiftSrc = ir[11];
                        ShamtSrc = ir[10];
                        popAmt   = ir[10];
                    end
                    OP_LOAD:  PushSrc = 3'b001;
                    default: ;
                endcase
            end
            S_HALT:  halted = 1'b1;
            S_FAULT: begin
                halted = 1'b1;
                fault  = 1'b1;
            end
            default: ;
        endcase
    end

    assign state = state_q;

endmodule
